// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, HI/LO selects and FSM state for the multiply/divide unit
package md_pkg;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  localparam logic HL_LO = 1'b0;
  localparam logic HL_HI = 1'b1;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/md_div_core.sv
// md_div_core: combinational signed/unsigned divide with sign fix-up and divide-by-zero flag
module md_div_core (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dz
);
  logic na, nb;
  logic [31:0] ua, ub, uq, ur;
  assign na = sgn & a[31];
  assign nb = sgn & b[31];
  assign ua = na ? -a : a;
  assign ub = nb ? -b : b;
  assign dz = b == 32'd0;
  assign uq = dz ? 32'd0 : ua / ub;
  assign ur = dz ? 32'd0 : ua % ub;
  // quotient truncates toward zero; remainder follows the dividend's sign
  assign q = (na ^ nb) ? -uq : uq;
  assign r = na ? -ur : ur;
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        we,
  input  logic        w_sel,
  input  logic        hl_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  state_t state;
  logic [CW-1:0] counter;
  logic [31:0] stage_hi, stage_lo;
  logic stage_skip, sx, dz;
  logic [63:0] prod;
  logic [31:0] q, r;
  assign sx = ~op[0];
  assign prod = {{32{sx & rs_val[31]}}, rs_val} * {{32{sx & rt_val[31]}}, rt_val};
  md_div_core u_div (.a(rs_val), .b(rt_val), .sgn(sx), .q(q), .r(r), .dz(dz));
  assign out = (hl_sel == HL_HI) ? hi : lo;
  // FSM: latch result at start, count down busy cycles, commit on the last one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      counter <= '0;
      stage_hi <= '0;
      stage_lo <= '0;
      stage_skip <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        busy <= 1'b1;
        counter <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        stage_hi <= op[1] ? r : prod[63:32];
        stage_lo <= op[1] ? q : prod[31:0];
        stage_skip <= op[1] & dz;
      end else if (we) begin
        if (w_sel == HL_HI) hi <= rs_val;
        else lo <= rs_val;
      end
    end else if (counter == CW'(1)) begin
      state <= IDLE;
      busy <= 1'b0;
      counter <= '0;
      if (!stage_skip) begin
        hi <= stage_hi;
        lo <= stage_lo;
      end
    end else begin
      counter <= counter - CW'(1);
    end
  end
endmodule
